// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type and byte-strobe merge helper for regfile_2r1w_clr.
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} regfile_state_t;
  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;
  // Callers size-cast their WIDTH-bit operands up to MAX_W and the result back down.
  function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0] old,
                                                  input logic [MAX_W-1:0] wdata,
                                                  input logic [MAX_B-1:0] wstrb);
    logic [MAX_W-1:0] r;
    for (int b = 0; b < MAX_B; b++) r[b*8+:8] = wstrb[b] ? wdata[b*8+:8] : old[b*8+:8];
    return r;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: registered read port with range/zero-reg masking and write forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ZERO_REG = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic             clearing,
  input  logic             fwd,
  input  logic [WIDTH-1:0] fwd_data,
  input  logic [WIDTH-1:0] mem [DEPTH],
  output logic [WIDTH-1:0] rdata
);
  logic             masked;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    masked = clearing || int'(raddr) >= DEPTH || (ZERO_REG != 0 && raddr == '0);
    nxt = masked ? '0 : fwd ? fwd_data : mem[raddr];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= nxt;
endmodule

// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: 2-read/1-write register file with byte strobes and a sequential bulk clear.
// Define REGFILE_2R1W_BYPASS_EN for write-first reads on same-address collisions.
module regfile_2r1w_clr
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ZERO_REG = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_req,
  output logic               busy,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic               re0,
  input  logic [AW-1:0]      raddr0,
  input  logic               re1,
  input  logic [AW-1:0]      raddr1,
  output logic [WIDTH-1:0]   rdata0,
  output logic [WIDTH-1:0]   rdata1
);
  logic [WIDTH-1:0] mem [DEPTH];
  regfile_state_t   state;
  logic [AW-1:0]    cnt;
  logic             wr_ok;
  logic [WIDTH-1:0] wr_data;
  logic             fwd0, fwd1;
  assign busy = state == CLEAR;
  always_comb begin
    wr_ok = state == IDLE && we && int'(waddr) < DEPTH && !(ZERO_REG != 0 && waddr == '0);
    wr_data = WIDTH'(strb_merge(MAX_W'(mem[waddr]), MAX_W'(wdata), MAX_B'(wstrb)));
  end
`ifdef REGFILE_2R1W_BYPASS_EN
  assign fwd0 = wr_ok && waddr == raddr0;
  assign fwd1 = wr_ok && waddr == raddr1;
`else
  assign fwd0 = 1'b0;
  assign fwd1 = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (state == CLEAR) mem[cnt] <= '0;
    else if (wr_ok) mem[waddr] <= wr_data;
  // The last clear edge behaves like IDLE so a held clr_req restarts without a gap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == IDLE || int'(cnt) == DEPTH - 1) begin
      state <= clr_req ? CLEAR : IDLE;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rp0 (
    .clk(clk), .rst_n(rst_n), .re(re0), .raddr(raddr0), .clearing(busy),
    .fwd(fwd0), .fwd_data(wr_data), .mem(mem), .rdata(rdata0)
  );
  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rp1 (
    .clk(clk), .rst_n(rst_n), .re(re1), .raddr(raddr1), .clearing(busy),
    .fwd(fwd1), .fwd_data(wr_data), .mem(mem), .rdata(rdata1)
  );
endmodule
